// File: rtl/gsim_pkg.sv
// Shared sizing and FSM encoding for the Gauss-Seidel solver feeder.
package gsim_pkg;
  localparam int VEC_LEN    = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int B_W        = 16;
  localparam int X_W        = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
endpackage

// File: rtl/gsim_fifo.sv
// Synchronous FIFO with occupancy count; push when full / pop when empty are dropped.
module gsim_fifo
  import gsim_pkg::*;
#(
  parameter int W     = B_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Explicit wrap so non-power-of-two depths stay correct.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gsim_feeder.sv
// Buffers host b vectors and streams one VEC_LEN job at a time into the solver.
module gsim_feeder
  import gsim_pkg::*;
#(
  parameter int VEC_LEN    = gsim_pkg::VEC_LEN,
  parameter int FIFO_DEPTH = gsim_pkg::FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [B_W-1:0] in_data,
  output logic           in_ready,
  output logic           gs_in_en,
  output logic [B_W-1:0] gs_b_in,
  input  logic           gs_out_valid,
  output logic           busy,
  output logic [1:0]     vec_cnt
);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int NW  = $clog2(VEC_LEN + 1);

  logic [1:0]     state;
  logic [NW-1:0]  issue_cnt;
  logic [NW-1:0]  outcnt;
  logic [CW-1:0]  count;
  logic           full;
  logic [B_W-1:0] head;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready = !full;
  assign gs_in_en = (state == ST_ISSUE);
  assign gs_b_in  = gs_in_en ? head : '0;
  assign busy     = (state != ST_IDLE);
  assign vec_cnt  = 2'(count / CW'(VEC_LEN));

  gsim_fifo #(.W(B_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (gs_in_en),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      outcnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          issue_cnt <= '0;
          if (count >= CW'(VEC_LEN)) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          issue_cnt <= issue_cnt + NW'(1);
          if (issue_cnt == NW'(VEC_LEN - 1)) begin
            state  <= ST_WAIT;
            outcnt <= '0;
          end
        end
        ST_WAIT: begin
          // Leaving WAIT only via IDLE keeps a cycle between the last result and the next job.
          if (gs_out_valid) begin
            outcnt <= outcnt + NW'(1);
            if (outcnt == NW'(VEC_LEN - 1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/gsim_feeder.md
GSIM_FEEDER -- requirements
Module: gsim_feeder

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16, meaning entries per b vector (one solver job).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, meaning buffered b entries (two vectors).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  host offers in_data.
REQ-006 SHALL have port in_data  input  16  signed b element, host order b1..b16.
REQ-007 SHALL have port in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 SHALL have port gs_in_en  output  1  drives solver in_en.
REQ-009 SHALL have port gs_b_in  output  16  drives solver b_in.
REQ-010 SHALL have port gs_out_valid  input  1  solver out_valid, used to track job completion.
REQ-011 SHALL have port busy  output  1  a job is in ISSUE or WAIT.
REQ-012 SHALL have port vec_cnt  output  2  complete vectors buffered (0..2).

Function
REQ-013 Host transfer SHALL occur on each cycle with in_valid=1 and in_ready=1; in_data SHALL be written to FIFO tail.
REQ-014 in_ready SHALL be 1 while FIFO occupancy < FIFO_DEPTH, including when a pop in the same cycle would free space (no combinational ready-from-pop path).
REQ-015 FSM states: IDLE, ISSUE, WAIT; reset state IDLE.
REQ-016 IDLE->ISSUE when occupancy >= VEC_LEN; first gs_in_en=1 on the cycle after the transition.
REQ-017 ISSUE: gs_in_en=1 for exactly VEC_LEN consecutive cycles, gs_b_in=FIFO head, one pop per cycle, strictly FIFO order; no gaps.
REQ-018 ISSUE->WAIT after the VEC_LEN-th pop; outcnt cleared.
REQ-019 WAIT: 5-bit outcnt increments on each gs_out_valid=1 cycle; on the cycle outcnt reaches VEC_LEN, WAIT->IDLE.
REQ-020 From IDLE a new ISSUE SHALL start no earlier than the cycle after the last gs_out_valid, so the solver is back in its receive state.
REQ-021 gs_out_valid asserted in IDLE or ISSUE SHALL be ignored (no count, no state change).
REQ-022 gs_in_en SHALL be 0 in IDLE and WAIT; gs_b_in SHALL be 0 whenever gs_in_en=0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 vec_cnt = floor(occupancy / VEC_LEN), registered-occupancy based.
REQ-025 busy=1 exactly in ISSUE and WAIT.
REQ-026 Data SHALL pass bit-exact (no rounding, sign extension, or reordering).

Reset
REQ-027 Reset SHALL force IDLE, occupancy 0, pointers 0, outcnt 0, and all outputs: in_ready=1 (after release), gs_in_en=0, gs_b_in=0, busy=0, vec_cnt=0.
REQ-028 Reset mid-ISSUE or mid-WAIT SHALL discard all buffered data; solver shares the same reset.

Structure
REQ-029 Shared package gsim_pkg SHALL hold VEC_LEN, FIFO_DEPTH, B_W=16, X_W=32, and the FSM state encoding.
REQ-030 Storage SHALL be one sub-module gsim_fifo (synchronous FIFO, width B_W, depth FIFO_DEPTH, async active-high reset, count output).

Verification
REQ-031 Push 1..16 back-to-back -> gs_in_en high 16 cycles starting 2 cycles after last push, gs_b_in 1..16 in order, busy=1.
REQ-032 Push 15 entries only -> gs_in_en stays 0, vec_cnt=0, busy=0 indefinitely.
REQ-033 Push 48 entries continuously -> in_ready drops at occupancy 32, resumes during ISSUE, no entry lost or duplicated; second job issued only the cycle after 16th gs_out_valid.
REQ-034 In WAIT pulse gs_out_valid 15 cycles -> stays WAIT; 16th pulse -> IDLE next cycle; stray gs_out_valid in IDLE -> no effect.
REQ-035 Assert reset at 8th ISSUE cycle -> gs_in_en=0, vec_cnt=0, in_ready=1 immediately; following 16 pushes issue normally.
REQ-036 Values 0x8000, 0x7FFF, 0xFFFF among input -> appear unchanged on gs_b_in.
